// File: rtl/swap_pkg.sv
// ---------------------------------------------------------------------------
// swap_pkg
// Shared definitions for the XOR swap engine:
//   - state_t       : FSM state encoding (IDLE=0 .. HOLD=4, 3 bits)
//   - DEFAULT_WIDTH : default operand width
//   - COUNT_MAX     : saturation value of the 16-bit transfer counter
// ---------------------------------------------------------------------------
package swap_pkg;

   localparam int          DEFAULT_WIDTH = 8;
   localparam logic [15:0] COUNT_MAX     = 16'hFFFF;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      XOR1 = 3'd1,
      XOR2 = 3'd2,
      XOR3 = 3'd3,
      HOLD = 3'd4
   } state_t;

endpackage

// File: rtl/sat_counter16.sv
// ---------------------------------------------------------------------------
// sat_counter16
// 16-bit up counter that sticks at COUNT_MAX instead of wrapping.
// Ports:
//   clk   - clock, counts on posedge
//   rst_n - asynchronous active-low reset, clears the count
//   inc   - increment request for this cycle
//   count - current count value
// ---------------------------------------------------------------------------
module sat_counter16
   import swap_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc,
   output logic [15:0] count
);

   logic [15:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (inc && (count_reg != COUNT_MAX)) begin
         count_reg <= count_reg + 16'd1;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/xor_swap_engine.sv
// ---------------------------------------------------------------------------
// xor_swap_engine
// Accepts an operand pair over a ready/valid handshake and returns it swapped,
// either directly (mode=0, 1-cycle latency) or via three XOR steps
// (mode=1, 4-cycle latency). Counts completed transfers, saturating.
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset
//   in_valid / in_ready - input handshake
//   in_a, in_b, mode    - operand pair and swap method, sampled at accept
//   out_valid/out_ready - output handshake
//   out_a, out_b        - swapped result (out_a = accepted in_b, out_b = in_a)
//   busy                - engine not idle
//   swap_count          - completed transfers, saturates at 16'hFFFF
// ---------------------------------------------------------------------------
module xor_swap_engine
   import swap_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic             busy,
   output logic [15:0]      swap_count
);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] ra_reg, ra_next;
   logic [WIDTH-1:0] rb_reg, rb_next;
   logic             accept;
   logic             drain;

   // Readiness comes from state and out_ready only; it is held low while
   // reset is asserted so nothing is offered to the producer during reset.
   assign in_ready  = rst_n && ((state_reg == IDLE) ||
                                ((state_reg == HOLD) && out_ready));
   assign accept    = in_valid && in_ready;
   assign drain     = (state_reg == HOLD) && out_ready;

   assign out_valid = (state_reg == HOLD);
   assign busy      = (state_reg != IDLE);
   assign out_a     = ra_reg;
   assign out_b     = rb_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         ra_reg    <= '0;
         rb_reg    <= '0;
      end else begin
         state_reg <= state_next;
         ra_reg    <= ra_next;
         rb_reg    <= rb_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      ra_next    = ra_reg;
      rb_next    = rb_reg;
      case (state_reg)
         IDLE, HOLD: begin
            // HOLD drains and may take a new pair on the same edge.
            if (accept) begin
               if (mode) begin
                  ra_next    = in_a;
                  rb_next    = in_b;
                  state_next = XOR1;
               end else begin
                  ra_next    = in_b;
                  rb_next    = in_a;
                  state_next = HOLD;
               end
            end else if (drain) begin
               state_next = IDLE;
            end
         end
         // Each XOR step uses the register values from before the edge.
         XOR1: begin
            ra_next    = ra_reg ^ rb_reg;
            state_next = XOR2;
         end
         XOR2: begin
            rb_next    = ra_reg ^ rb_reg;
            state_next = XOR3;
         end
         XOR3: begin
            ra_next    = ra_reg ^ rb_reg;
            state_next = HOLD;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   sat_counter16 u_count (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (drain),
      .count (swap_count)
   );

endmodule
